// File: rtl/alu_exec_seq.sv
// Execute-stage ALU with valid/ready handshake; shifts run one bit per cycle unless
// ALU_FAST_SHIFT_EN is defined, which swaps in a single-cycle barrel shifter.
module alu_exec_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic             busy
);

   localparam logic [3:0] CTL_ADD  = 4'b0000;
   localparam logic [3:0] CTL_SUB  = 4'b1000;
   localparam logic [3:0] CTL_SLL  = 4'b0001;
   localparam logic [3:0] CTL_SLT  = 4'b0010;
   localparam logic [3:0] CTL_SLTU = 4'b0011;
   localparam logic [3:0] CTL_XOR  = 4'b0100;
   localparam logic [3:0] CTL_SRL  = 4'b0101;
   localparam logic [3:0] CTL_SRA  = 4'b1101;
   localparam logic [3:0] CTL_OR   = 4'b0110;
   localparam logic [3:0] CTL_AND  = 4'b0111;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q;
   logic               zero_q, illegal_q;
   logic [WIDTH-1:0]   alu_res;
   logic               legal;
   logic               accept;
   logic               start_shift;
   logic [SHAMT_W-1:0] shamt;
   logic               shift_done;

   assign accept = in_valid & in_ready;
   assign shamt  = op_b[SHAMT_W-1:0];

   // Single-cycle result; in the iterative build shifts with shamt==0 pass op_a through.
   always_comb begin
      alu_res = '0;
      legal   = 1'b1;
      case (alu_ctl)
         CTL_ADD:  alu_res = op_a + op_b;
         CTL_SUB:  alu_res = op_a - op_b;
         CTL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         CTL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         CTL_XOR:  alu_res = op_a ^ op_b;
         CTL_OR:   alu_res = op_a | op_b;
         CTL_AND:  alu_res = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
         CTL_SLL:  alu_res = op_a << shamt;
         CTL_SRL:  alu_res = op_a >> shamt;
         CTL_SRA:  alu_res = $signed(op_a) >>> shamt;
`else
         CTL_SLL, CTL_SRL, CTL_SRA: alu_res = op_a;
`endif
         default:  legal = 1'b0;
      endcase
   end

`ifdef ALU_FAST_SHIFT_EN
   assign start_shift = 1'b0;
   assign shift_done  = 1'b0;
`else
   logic [WIDTH-1:0]   sh_q, sh_next;
   logic [SHAMT_W-1:0] cnt_q;
   logic               sh_left_q, sh_arith_q;

   assign start_shift = accept & (shamt != '0) &
                        ((alu_ctl == CTL_SLL) | (alu_ctl == CTL_SRL) | (alu_ctl == CTL_SRA));
   assign shift_done  = (cnt_q == SHAMT_W'(1));
   assign sh_next     = sh_left_q ? {sh_q[WIDTH-2:0], 1'b0}
                                  : {sh_arith_q & sh_q[WIDTH-1], sh_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q       <= '0;
         cnt_q      <= '0;
         sh_left_q  <= 1'b0;
         sh_arith_q <= 1'b0;
      end else if (start_shift) begin
         sh_q       <= op_a;
         cnt_q      <= shamt;
         sh_left_q  <= (alu_ctl == CTL_SLL);
         sh_arith_q <= (alu_ctl == CTL_SRA);
      end else if (state_q == S_SHIFT) begin
         sh_q  <= sh_next;
         cnt_q <= cnt_q - SHAMT_W'(1);
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = start_shift ? S_SHIFT : S_DONE;
         S_SHIFT: if (shift_done) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
   end

   // Result registers only move on accept or final shift step, so they hold under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else if (accept) begin
         illegal_q <= ~legal;
         if (!start_shift) begin
            result_q <= alu_res;
            zero_q   <= (alu_res == '0);
         end
`ifndef ALU_FAST_SHIFT_EN
      end else if (state_q == S_SHIFT && shift_done) begin
         result_q <= sh_next;
         zero_q   <= (sh_next == '0);
`endif
      end
   end

   assign result  = result_q;
   assign zero    = zero_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed scoreboard bench for alu_exec_seq: latency, results, flags, backpressure, reset abort.
module tb_alu_exec_seq;

`ifdef ALU_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [3:0]  alu_ctl;
   logic [31:0] op_a, op_b;
   logic        out_valid, out_ready;
   logic [31:0] result;
   logic        zero, illegal, busy;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ill;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   alu_exec_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   function automatic int shift_lat(input logic [31:0] b);
      return FAST ? 1 : 1 + int'(b[4:0]);
   endfunction

   // Drive one request, wait for its result, compare against the scoreboard head,
   // optionally hold out_ready low for `hold` cycles, then release it.
   task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ez,
                         input logic ei, input int elat, input int hold);
      exp_t e;
      int   n;
      logic ir_hi;
      logic [31:0] r0;
      e.res = er; e.z = ez; e.ill = ei; e.lat = elat;
      sb.push_back(e);
      @(negedge clk);
      chk({tag, " in_ready before"}, in_ready, 1);
      in_valid = 1'b1; alu_ctl = ctl; op_a = a; op_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1; ir_hi = 1'b0;
      while (!out_valid && n < 64) begin
         if (in_ready) ir_hi = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      e = sb.pop_front();
      chk({tag, " out_valid"}, out_valid, 1);
      chk({tag, " latency"}, n, e.lat);
      if (e.lat > 1) chk({tag, " in_ready low while shifting"}, ir_hi, 0);
      chk({tag, " result"}, result, e.res);
      chk({tag, " zero"}, zero, e.z);
      chk({tag, " illegal"}, illegal, e.ill);
      r0 = result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, " hold result"}, result, r0);
         chk({tag, " hold out_valid"}, out_valid, 1);
         chk({tag, " hold in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " released out_valid"}, out_valid, 0);
      chk({tag, " released in_ready"}, in_ready, 1);
   endtask

   initial begin
      logic        ov_seen;
      logic [31:0] ra, rb;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      alu_ctl = 4'h0; op_a = '0; op_b = '0;
      #12;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset result", result, 0);
      chk("reset zero", zero, 0);
      chk("reset illegal", illegal, 0);
      chk("reset busy", busy, 0);
      @(negedge clk); rst = 1'b0;

      run_op("ADD",  4'b0000, 32'h7FFF_FFFF, 32'h1,    32'h8000_0000, 0, 0, 1, 3);
      run_op("SUB",  4'b1000, 32'h1234,      32'h1234, 32'h0,         1, 0, 1, 0);
      run_op("SLT",  4'b0010, 32'hFFFF_FFFF, 32'h1,    32'h1,         0, 0, 1, 0);
      run_op("SLTU", 4'b0011, 32'hFFFF_FFFF, 32'h1,    32'h0,         1, 0, 1, 0);
      run_op("SRA4", 4'b1101, 32'h8000_0000, 32'h24,   32'hF800_0000, 0, 0, shift_lat(32'h24), 0);
      run_op("SLL0", 4'b0001, 32'hA5,        32'h20,   32'hA5,        0, 0, 1, 0);
      run_op("ILL",  4'b1111, 32'h1234,      32'h5678, 32'h0,         1, 1, 1, 0);
      run_op("AND",  4'b0111, 32'hF0,        32'h3C,   32'h30,        0, 0, 1, 0);
      run_op("ILL9", 4'b1001, 32'h1,         32'h1,    32'h0,         1, 1, 1, 0);
      run_op("OR",   4'b0110, 32'hF0F0_0000, 32'h0F0F, 32'hF0F0_0F0F, 0, 0, 1, 0);
      run_op("XOR",  4'b0100, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0,    1, 0, 1, 0);
      run_op("SRL1", 4'b0101, 32'hF000_0001, 32'hFFFF_FFE1, 32'h7800_0000, 0, 0, shift_lat(32'h1), 2);
      run_op("SLL31",4'b0001, 32'h3,         32'h1F,   32'h8000_0000, 0, 0, shift_lat(32'h1F), 0);
      run_op("SRA31",4'b1101, 32'h7FFF_FFFF, 32'h1F,   32'h0,         1, 0, shift_lat(32'h1F), 0);

      for (int k = 0; k < 4; k++) begin
         ra = $urandom; rb = $urandom;
         run_op("rADD", 4'b0000, ra, rb, ra + rb, (ra + rb) == 0, 0, 1, 0);
         run_op("rSLL", 4'b0001, ra, rb, ra << rb[4:0], (ra << rb[4:0]) == 0, 0, shift_lat(rb), 0);
      end

      // Reset in the middle of SRL by 20 must discard the op.
      @(negedge clk);
      in_valid = 1'b1; alu_ctl = 4'b0101; op_a = 32'hFFFF_0000; op_b = 32'h14;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("rst-mid busy", busy, 1);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst-mid out_valid", out_valid, 0);
      chk("rst-mid in_ready", in_ready, 1);
      chk("rst-mid busy idle", busy, 0);
      chk("rst-mid result", result, 0);
      @(negedge clk); rst = 1'b0;
      ov_seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) ov_seen = 1'b1;
      end
      chk("rst-mid no stale output", ov_seen, 0);

      run_op("post-rst ADD", 4'b0000, 32'h5, 32'h7, 32'hC, 0, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
